// File: rtl/load_manager_axil.sv
// ---------------------------------------------------------------------------
// Module: load_manager_axil
// Purpose:
//   AXI4-Lite slave that balances requests across three FPGA workers.
//   Software programs each worker's station number and then writes REQUEST.
//   The block picks the worker with the smallest load counter (ties go to the
//   lowest index), publishes its station number in STATION_NO and bumps that
//   worker's counter, which saturates at all-ones.
//
// Register map (byte offsets, addr[1:0] ignored):
//   0x00/0x04/0x08  FPGA1..3 station number (RW, byte strobes honoured)
//   0x0C/0x10/0x14  LOAD1..3 counters (RO, any write clears the counter)
//   0x18            REQUEST (write wdata[0]=1 to assign, reads 0)
//   0x1C            STATION_NO (RO)
//   other offsets   read 0, writes ignored, response OKAY
//
// Ports:
//   clk, resetn                  clock and synchronous active-low reset
//   s_axi_aw*/s_axi_w*/s_axi_b*  AXI4-Lite write address, data, response
//   s_axi_ar*/s_axi_r*           AXI4-Lite read address and data
// ---------------------------------------------------------------------------
module load_manager_axil #(
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    logic                  r_alive;
    logic                  r_awCaptured;
    logic                  r_wCaptured;
    logic                  r_bvalid;
    logic [ADDR_WIDTH-1:2] r_awAddr;
    logic [31:0]           r_wData;
    logic [3:0]            r_wStrb;
    logic [31:0]           r_station [3];
    logic [CNT_WIDTH-1:0]  r_load [3];
    logic [31:0]           r_stationNo;
    logic                  r_rvalid;
    logic [31:0]           r_rdata;

    logic                  w_awready;
    logic                  w_wready;
    logic                  w_arready;
    logic                  w_commit;
    logic                  w_wrInRange;
    logic [2:0]            w_wrIndex;
    logic                  w_rdInRange;
    logic [2:0]            w_rdIndex;
    logic [1:0]            w_selIdx;
    logic [31:0]           w_selStation;
    logic [31:0]           w_rdataNext;
    logic                  w_unused;

    // r_alive keeps every ready low while reset is applied and for the
    // first edge after it, so no handshake can straddle reset release.
    assign w_awready = r_alive && !r_awCaptured && !r_bvalid;
    assign w_wready  = r_alive && !r_wCaptured  && !r_bvalid;
    assign w_arready = r_alive && !r_rvalid;
    assign w_commit  = r_awCaptured && r_wCaptured && !r_bvalid;

    // Only offsets 0x00..0x1C are backed by registers.
    assign w_wrInRange = (r_awAddr[ADDR_WIDTH-1:5] == '0);
    assign w_wrIndex   = r_awAddr[4:2];
    assign w_rdInRange = (s_axi_araddr[ADDR_WIDTH-1:5] == '0);
    assign w_rdIndex   = s_axi_araddr[4:2];

    assign w_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign s_axi_awready = w_awready;
    assign s_axi_wready  = w_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = w_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = 2'b00;

    // Least-loaded worker; the <= comparisons give ties to the lower index.
    always_comb begin
        w_selIdx = 2'd2;
        if (r_load[0] <= r_load[1] && r_load[0] <= r_load[2]) begin
            w_selIdx = 2'd0;
        end else if (r_load[1] <= r_load[2]) begin
            w_selIdx = 2'd1;
        end
    end

    always_comb begin
        case (w_selIdx)
            2'd0:    w_selStation = r_station[0];
            2'd1:    w_selStation = r_station[1];
            default: w_selStation = r_station[2];
        endcase
    end

    // Write channel: AW and W are captured independently, the write commits
    // one edge after both are held, and no new beat is taken until the
    // response has been accepted.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_alive      <= 1'b0;
            r_awCaptured <= 1'b0;
            r_wCaptured  <= 1'b0;
            r_bvalid     <= 1'b0;
            r_awAddr     <= '0;
            r_wData      <= '0;
            r_wStrb      <= '0;
        end else begin
            r_alive <= 1'b1;
            if (s_axi_awvalid && w_awready) begin
                r_awCaptured <= 1'b1;
                r_awAddr     <= s_axi_awaddr[ADDR_WIDTH-1:2];
            end
            if (s_axi_wvalid && w_wready) begin
                r_wCaptured <= 1'b1;
                r_wData     <= s_axi_wdata;
                r_wStrb     <= s_axi_wstrb;
            end
            if (w_commit) begin
                r_awCaptured <= 1'b0;
                r_wCaptured  <= 1'b0;
                r_bvalid     <= 1'b1;
            end else if (r_bvalid && s_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Register file, load counters and the assignment itself, all updated
    // on the commit edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 3; i++) begin
                r_station[i] <= '0;
                r_load[i]    <= '0;
            end
            r_stationNo <= '0;
        end else if (w_commit && w_wrInRange) begin
            for (int i = 0; i < 3; i++) begin
                if (w_wrIndex == 3'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (r_wStrb[b]) begin
                            r_station[i][8*b +: 8] <= r_wData[8*b +: 8];
                        end
                    end
                end
                if (w_wrIndex == 3'(i + 3)) begin
                    r_load[i] <= '0;
                end
            end
            if (w_wrIndex == 3'd6 && r_wData[0]) begin
                r_stationNo <= w_selStation;
                for (int i = 0; i < 3; i++) begin
                    if (w_selIdx == 2'(i) && r_load[i] != '1) begin
                        r_load[i] <= r_load[i] + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    // Read data mux, sampled on the AR handshake.
    always_comb begin
        w_rdataNext = '0;
        if (w_rdInRange) begin
            case (w_rdIndex)
                3'd0:    w_rdataNext = r_station[0];
                3'd1:    w_rdataNext = r_station[1];
                3'd2:    w_rdataNext = r_station[2];
                3'd3:    w_rdataNext = 32'(r_load[0]);
                3'd4:    w_rdataNext = 32'(r_load[1]);
                3'd5:    w_rdataNext = 32'(r_load[2]);
                3'd7:    w_rdataNext = r_stationNo;
                default: w_rdataNext = '0;
            endcase
        end
    end

    // Read channel: data is registered one edge after AR and held until
    // the master takes it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (s_axi_arvalid && w_arready) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rdataNext;
        end else if (r_rvalid && s_axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_load_manager_axil.sv
// ---------------------------------------------------------------------------
// Testbench for load_manager_axil.
// Stimulus tasks drive AXI4-Lite transactions and push expected responses
// into queues; a monitor process pops and compares them whenever the DUT
// completes a read or write response. The reference model keeps the
// register map as plain arrays and picks the least-loaded worker by a
// linear search.
// ---------------------------------------------------------------------------
module tb_load_manager_axil;

    localparam int ADDR_WIDTH = 8;
    localparam int CNT_WIDTH  = 16;
    localparam int CNT_MAX    = (1 << CNT_WIDTH) - 1;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [7:0]  s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;

    always #5 clk = ~clk;

    load_manager_axil #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wstrb  (s_axi_wstrb),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready)
    );

    typedef struct {
        string       name;
        logic [31:0] actual;
        logic [31:0] expected;
    } checkT;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } readExpT;

    checkT      checkQ[$];
    readExpT    readQ[$];
    logic [1:0] bQ[$];

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] mStation[3];
    int          mLoad[3];
    logic [31:0] mStationNo;

    // Reference model ------------------------------------------------------
    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            mStation[i] = '0;
            mLoad[i]    = 0;
        end
        mStationNo = '0;
    endtask

    function automatic logic [31:0] modelRead(input logic [7:0] addr);
        int slot;
        slot = int'(addr) / 4;
        if (slot <= 2) return mStation[slot];
        if (slot <= 5) return 32'(mLoad[slot - 3]);
        if (slot == 7) return mStationNo;
        return 32'h0;
    endfunction

    task automatic modelWrite(input logic [7:0] addr, input logic [31:0] data,
                              input logic [3:0] strb);
        int slot;
        int best;
        slot = int'(addr) / 4;
        if (slot <= 2) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mStation[slot][8*b +: 8] = data[8*b +: 8];
            end
        end else if (slot <= 5) begin
            mLoad[slot - 3] = 0;
        end else if (slot == 6 && data[0]) begin
            best = 0;
            for (int i = 1; i < 3; i++) begin
                if (mLoad[i] < mLoad[best]) best = i;
            end
            mStationNo = mStation[best];
            if (mLoad[best] < CNT_MAX) mLoad[best] = mLoad[best] + 1;
        end
    endtask

    // Checking -------------------------------------------------------------
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic pushCheck(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
        checkT c;
        c.name     = name;
        c.actual   = actual;
        c.expected = expected;
        checkQ.push_back(c);
    endtask

    // Monitor: the only process that compares and counts.
    initial begin
        checkT   c;
        readExpT e;
        logic [1:0] br;
        forever begin
            @(negedge clk);
            while (checkQ.size() > 0) begin
                c = checkQ.pop_front();
                checkOutput(c.name, c.actual, c.expected);
            end
            if (resetn && s_axi_rvalid && s_axi_rready) begin
                if (readQ.size() == 0) begin
                    checkOutput("unexpected read response", 32'h1, 32'h0);
                end else begin
                    e = readQ.pop_front();
                    checkOutput($sformatf("rdata @0x%02h", e.addr), s_axi_rdata, e.data);
                    checkOutput("rresp", 32'(s_axi_rresp), 32'h0);
                end
            end
            if (resetn && s_axi_bvalid && s_axi_bready) begin
                if (bQ.size() == 0) begin
                    checkOutput("unexpected write response", 32'h1, 32'h0);
                end else begin
                    br = bQ.pop_front();
                    checkOutput("bresp", 32'(s_axi_bresp), 32'(br));
                end
            end
        end
    end

    // Stimulus tasks -------------------------------------------------------
    task automatic doReset();
        @(posedge clk);
        #1;
        resetn        = 1'b0;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_arvalid = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_rready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        pushCheck("reset ready/valid outputs",
                  {27'b0, s_axi_awready, s_axi_wready, s_axi_arready,
                   s_axi_bvalid, s_axi_rvalid}, 32'h0);
        modelReset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic writeReg(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int awDelay,
                            input int wDelay, input int bStall);
        bit awDone;
        bit wDone;
        bit awHs;
        bit wHs;
        int n;
        awDone = 1'b0;
        wDone  = 1'b0;
        for (int c = 0; c < 60 && !(awDone && wDone); c++) begin
            @(negedge clk);
            if (!awDone && c >= awDelay) begin
                s_axi_awaddr  = addr;
                s_axi_awvalid = 1'b1;
            end
            if (!wDone && c >= wDelay) begin
                s_axi_wdata  = data;
                s_axi_wstrb  = strb;
                s_axi_wvalid = 1'b1;
            end
            awHs = s_axi_awvalid && s_axi_awready;
            wHs  = s_axi_wvalid && s_axi_wready;
            @(posedge clk);
            #1;
            if (awHs) begin
                awDone        = 1'b1;
                s_axi_awvalid = 1'b0;
            end
            if (wHs) begin
                wDone        = 1'b1;
                s_axi_wvalid = 1'b0;
            end
        end
        if (!(awDone && wDone)) begin
            pushCheck("write address/data accept timeout", 32'h0, 32'h1);
            s_axi_awvalid = 1'b0;
            s_axi_wvalid  = 1'b0;
            return;
        end
        n = 0;
        @(negedge clk);
        while (!s_axi_bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!s_axi_bvalid) begin
            pushCheck("bvalid timeout", 32'h0, 32'h1);
            return;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < bStall; i++) begin
            pushCheck("bvalid held while bready low", 32'(s_axi_bvalid), 32'h1);
            @(posedge clk);
            #1;
        end
        bQ.push_back(2'b00);
        s_axi_bready = 1'b1;
        @(posedge clk);
        #1;
        s_axi_bready = 1'b0;
        pushCheck("bvalid cleared after handshake", 32'(s_axi_bvalid), 32'h0);
        modelWrite(addr, data, strb);
    endtask

    task automatic readReg(input logic [7:0] addr);
        int      n;
        readExpT e;
        @(negedge clk);
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!s_axi_arready) begin
            pushCheck("arready timeout", 32'h0, 32'h1);
            s_axi_arvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        s_axi_arvalid = 1'b0;
        e.addr = addr;
        e.data = modelRead(addr);
        readQ.push_back(e);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        s_axi_rready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!s_axi_rvalid) begin
            pushCheck("rvalid timeout", 32'h0, 32'h1);
            s_axi_rready = 1'b0;
            void'(readQ.pop_back());
            return;
        end
        @(posedge clk);
        #1;
        s_axi_rready = 1'b0;
    endtask

    task automatic readAll();
        for (int i = 0; i < 8; i++) readReg(8'(4 * i));
    endtask

    task automatic applyStimulus(input int count);
        for (int k = 0; k < count; k++) begin
            int          op;
            int          aw;
            int          wd;
            int          bs;
            logic [31:0] data;
            op   = int'($urandom_range(0, 5));
            aw   = int'($urandom_range(0, 2));
            wd   = int'($urandom_range(0, 2));
            bs   = int'($urandom_range(0, 2));
            data = $urandom;
            case (op)
                0: writeReg(8'(4 * $urandom_range(0, 2)), data,
                            4'($urandom_range(0, 15)), aw, wd, bs);
                1: begin
                    data[0] = ($urandom_range(0, 3) != 0);
                    writeReg(8'h18, data, 4'hF, aw, wd, bs);
                end
                2: writeReg(8'(12 + 4 * $urandom_range(0, 2)), data, 4'hF, aw, wd, bs);
                3: readReg(8'($urandom_range(0, 31)));
                4: readReg(8'($urandom_range(0, 255)));
                default: writeReg(8'($urandom_range(28, 255)), data, 4'hF, aw, wd, bs);
            endcase
        end
    endtask

    // Watchdog: ends the run if anything stalls beyond every bounded wait.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence -------------------------------------------------------
    initial begin
        modelReset();
        doReset();
        readAll();

        writeReg(8'h00, 32'h2, 4'hF, 0, 0, 0);
        writeReg(8'h04, 32'h4, 4'hF, 0, 0, 0);
        writeReg(8'h08, 32'h6, 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            writeReg(8'h18, 32'h1, 4'hF, 0, 0, 0);
            readReg(8'h1C);
        end
        readReg(8'h0C);
        readReg(8'h10);
        readReg(8'h14);

        writeReg(8'h10, 32'h0, 4'hF, 0, 0, 0);
        writeReg(8'h18, 32'h1, 4'hF, 0, 0, 0);
        readReg(8'h1C);

        writeReg(8'h18, 32'h0, 4'hF, 0, 0, 0);
        readReg(8'h1C);
        readReg(8'h0C);
        readReg(8'h10);
        readReg(8'h14);

        writeReg(8'h18, 32'h1, 4'hF, 1, 0, 3);
        readAll();

        writeReg(8'h00, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
        readReg(8'h00);
        readReg(8'h03);
        writeReg(8'h1C, 32'h12345678, 4'hF, 0, 1, 1);
        writeReg(8'h20, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        readReg(8'h1C);
        readReg(8'h20);
        readReg(8'hFC);

        fork
            writeReg(8'h08, 32'h0000BEEF, 4'hF, 0, 0, 0);
            readReg(8'h1C);
        join
        readReg(8'h08);

        applyStimulus(80);
        readAll();

        writeReg(8'h18, 32'h1, 4'hF, 0, 0, 0);
        writeReg(8'h18, 32'h1, 4'hF, 2, 0, 1);
        doReset();
        readAll();
        writeReg(8'h04, 32'h77, 4'hF, 0, 0, 0);
        writeReg(8'h18, 32'h1, 4'hF, 0, 0, 0);
        readAll();

        pushCheck("leftover read expectations", 32'(readQ.size()), 32'h0);
        pushCheck("leftover write expectations", 32'(bQ.size()), 32'h0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
